// File: rtl/xb_subband_wr.sv
// xb_subband_wr: write-back stage for the level-2 wavelet subbands.
// Buffers {2h_h, 2h_l, 2l_h, 2l_l} sample sets in a small FIFO and serializes
// them as 16-bit words, one band region per band, onto the DDR write port.
module xb_subband_wr #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned BAND_SIZE = 4096
) (
  input  logic              phy_clk_0,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [15:0]       data_2l_l,
  input  logic [15:0]       data_2l_h,
  input  logic [15:0]       data_2h_l,
  input  logic [15:0]       data_2h_h,
  input  logic              finish_in,
  input  logic              wr_ready,
  output logic              wr_en,
  output logic [15:0]       wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              overflow,
  output logic              done
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned IdxW = (BAND_SIZE > 1) ? $clog2(BAND_SIZE) : 1;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  logic [63:0]       mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [CntW-1:0]   count_q, count_d;
  state_e            state_q;
  logic [1:0]        band_q, band_nxt;
  logic [IdxW-1:0]   idx_q, idx_inc;
  logic              fin_q, fin_d;
  logic              overflow_q, done_q;
  logic              wr_en_q;
  logic [15:0]       wr_data_q;
  logic [ADDR_W-1:0] wr_addr_q;

  logic [63:0] in_set, head_set, next_set;
  logic        fifo_full, fifo_empty, xfer, pop, push;

  function automatic logic [15:0] band_word(input logic [63:0] set, input logic [1:0] band);
    return set[{band, 4'b0000} +: 16];
  endfunction

  // Wraps modulo 2^ADDR_W through the sized casts.
  function automatic logic [ADDR_W-1:0] band_addr(input logic [1:0] band,
                                                  input logic [IdxW-1:0] idx);
    return ADDR_W'(BASE_ADDR) + ADDR_W'(band) * ADDR_W'(BAND_SIZE) + ADDR_W'(idx);
  endfunction

  assign in_set     = {data_2h_h, data_2h_l, data_2l_h, data_2l_l};
  assign fifo_full  = (count_q == CntW'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign xfer       = (state_q == StSend) && wr_en_q && wr_ready;
  assign pop        = xfer && (band_q == 2'd3);
  assign push       = in_valid && (!fifo_full || pop);
  assign rd_ptr_nxt = rd_ptr_q + PtrW'(1);
  assign band_nxt   = band_q + 2'd1;
  assign idx_inc    = (idx_q == IdxW'(BAND_SIZE - 1)) ? '0 : idx_q + IdxW'(1);
  assign head_set   = mem_q[rd_ptr_q];
  // With only the popped head left, the new head is the set being pushed this edge.
  assign next_set   = (count_q > CntW'(1)) ? mem_q[rd_ptr_nxt] : in_set;
  assign fin_d      = fin_q | finish_in;

  // Occupancy after this edge; simultaneous push and pop cancel.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Sample-set storage; contents need no reset since occupancy guards reads.
  always_ff @(posedge phy_clk_0) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_set;
    end
  end

  // FIFO pointers, occupancy and the sticky finish/overflow/done flags.
  always_ff @(posedge phy_clk_0) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fin_q      <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_nxt;
      end
      count_q <= count_d;
      fin_q   <= fin_d;
      if (in_valid && !push) begin
        overflow_q <= 1'b1;
      end
      // An empty FIFO after this edge implies the drain FSM is idle after it too.
      if (fin_d && (count_d == '0)) begin
        done_q <= 1'b1;
      end
    end
  end

  // Drain FSM with registered write-port outputs.
  always_ff @(posedge phy_clk_0) begin
    if (!reset) begin
      state_q   <= StIdle;
      band_q    <= 2'd0;
      idx_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      wr_addr_q <= ADDR_W'(BASE_ADDR);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            band_q    <= 2'd0;
            wr_en_q   <= 1'b1;
            wr_data_q <= band_word(head_set, 2'd0);
            wr_addr_q <= band_addr(2'd0, idx_q);
            state_q   <= StSend;
          end
        end
        StSend: begin
          if (xfer) begin
            if (band_q != 2'd3) begin
              band_q    <= band_nxt;
              wr_data_q <= band_word(head_set, band_nxt);
              wr_addr_q <= band_addr(band_nxt, idx_q);
            end else begin
              band_q <= 2'd0;
              idx_q  <= idx_inc;
              if ((count_q > CntW'(1)) || push) begin
                wr_data_q <= band_word(next_set, 2'd0);
                wr_addr_q <= band_addr(2'd0, idx_inc);
              end else begin
                wr_en_q <= 1'b0;
                state_q <= StIdle;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_data  = wr_data_q;
  assign wr_addr  = wr_addr_q;
  assign overflow = overflow_q;
  assign done     = done_q;

endmodule

// File: tb/tb_xb_subband_wr.sv
// Bench for xb_subband_wr: two instances (wide and narrow address space) share stimulus.
module tb_xb_subband_wr;

  localparam int unsigned Depth = 8;
  localparam int unsigned BaseA = 'h100;
  localparam int unsigned BandA = 'h1000;
  localparam int unsigned BaseB = 'hF8;
  localparam int unsigned BandB = 4;

  logic phy_clk_0 = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic finish_in = 1'b0;
  logic wr_ready = 1'b0;
  logic [15:0] d_ll = '0, d_lh = '0, d_hl = '0, d_hh = '0;

  logic        wr_en_a, wr_en_b, ovf_a, ovf_b, done_a, done_b;
  logic [15:0] wr_data_a, wr_data_b;
  logic [23:0] wr_addr_a;
  logic [7:0]  wr_addr_b;

  always #5 phy_clk_0 = ~phy_clk_0;

  xb_subband_wr #(
    .DEPTH(Depth), .ADDR_W(24), .BASE_ADDR(BaseA), .BAND_SIZE(BandA)
  ) u_dut_a (
    .phy_clk_0(phy_clk_0), .reset(reset), .in_valid(in_valid),
    .data_2l_l(d_ll), .data_2l_h(d_lh), .data_2h_l(d_hl), .data_2h_h(d_hh),
    .finish_in(finish_in), .wr_ready(wr_ready), .wr_en(wr_en_a), .wr_data(wr_data_a),
    .wr_addr(wr_addr_a), .overflow(ovf_a), .done(done_a)
  );

  xb_subband_wr #(
    .DEPTH(Depth), .ADDR_W(8), .BASE_ADDR(BaseB), .BAND_SIZE(BandB)
  ) u_dut_b (
    .phy_clk_0(phy_clk_0), .reset(reset), .in_valid(in_valid),
    .data_2l_l(d_ll), .data_2l_h(d_lh), .data_2h_l(d_hl), .data_2h_h(d_hh),
    .finish_in(finish_in), .wr_ready(wr_ready), .wr_en(wr_en_b), .wr_data(wr_data_b),
    .wr_addr(wr_addr_b), .overflow(ovf_b), .done(done_b)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] addr_a(input int band, input int idx);
    return 24'(BaseA + band * BandA + idx);
  endfunction

  function automatic logic [7:0] addr_b(input int band, input int idx);
    return 8'(BaseB + band * BandB + idx);
  endfunction

  // Reference model: queue of accepted sets, the word of the head being offered,
  // and completed-set counters for each address space.
  logic [63:0] mq[$];
  bit m_en = 0, m_ovf = 0, m_done = 0, m_fin = 0;
  int m_k = 0, m_ia = 0, m_ib = 0;

  always @(posedge phy_clk_0) begin
    bit xfer, pop, acc;
    if (!reset) begin
      mq.delete();
      m_en = 0; m_ovf = 0; m_done = 0; m_fin = 0;
      m_k = 0; m_ia = 0; m_ib = 0;
    end else begin
      xfer = m_en && wr_ready;
      pop  = xfer && (m_k == 3);
      acc  = in_valid && ((mq.size() < Depth) || pop);
      if (in_valid && !acc) m_ovf = 1;
      if (finish_in) m_fin = 1;
      if (!m_en) m_en = (mq.size() != 0);
      if (xfer) begin
        if (m_k < 3) m_k++;
        else begin
          void'(mq.pop_front());
          m_k = 0;
          m_ia = (m_ia + 1) % BandA;
          m_ib = (m_ib + 1) % BandB;
        end
      end
      if (acc) mq.push_back({d_hh, d_hl, d_lh, d_ll});
      if (pop) m_en = (mq.size() != 0);
      if (m_fin && (mq.size() == 0) && !m_en) m_done = 1;
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge phy_clk_0) begin
    logic [63:0] h;
    if (chk_on) begin
      chk("model_wr_en_a", wr_en_a, m_en);
      chk("model_wr_en_b", wr_en_b, m_en);
      chk("model_ovf_a", ovf_a, m_ovf);
      chk("model_ovf_b", ovf_b, m_ovf);
      chk("model_done_a", done_a, m_done);
      chk("model_done_b", done_b, m_done);
      if (m_en && mq.size() != 0) begin
        h = mq[0];
        chk("model_data_a", wr_data_a, h[m_k*16 +: 16]);
        chk("model_data_b", wr_data_b, h[m_k*16 +: 16]);
        chk("model_addr_a", wr_addr_a, addr_a(m_k, m_ia));
        chk("model_addr_b", wr_addr_b, addr_b(m_k, m_ib));
      end
    end
  end

  // Completed transfers as {addr, data}.
  logic [39:0] cap_a[$];
  logic [23:0] cap_b[$];

  always @(negedge phy_clk_0) begin
    if (chk_on && reset && wr_ready) begin
      if (wr_en_a) cap_a.push_back({wr_addr_a, wr_data_a});
      if (wr_en_b) cap_b.push_back({wr_addr_b, wr_data_b});
    end
  end

  task automatic tick();
    @(posedge phy_clk_0);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; in_valid = 1'b0; finish_in = 1'b0; wr_ready = 1'b0;
    tick();
    chk_on = 1;
    tick();
    reset = 1'b1;
    cap_a.delete();
    cap_b.delete();
  endtask

  task automatic push(input logic [63:0] set);
    in_valid = 1'b1;
    {d_hh, d_hl, d_lh, d_ll} = set;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_caps(input int n, input int budget);
    int c = 0;
    while ((cap_a.size() < n || cap_b.size() < n) && c < budget) begin
      tick();
      c++;
    end
    repeat (6) tick();
    chk("word_count_a", cap_a.size(), n);
    chk("word_count_b", cap_b.size(), n);
  endtask

  typedef struct {
    logic [63:0] set;
    logic [23:0] a0;
    logic [7:0]  b0;
  } vec_t;

  vec_t        tbl[3];
  logic [63:0] bp_sets[3];

  initial begin
    logic [63:0] s;
    logic [23:0] pa;
    logic [7:0]  pb;
    logic [15:0] pd;
    logic        stalled;
    int          c;

    tbl[0] = '{set: 64'h0000_FFFF_5A5A_A5A5, a0: 24'h000101, b0: 8'hF9};
    tbl[1] = '{set: 64'hDEF0_9ABC_5678_1234, a0: 24'h000102, b0: 8'hFA};
    tbl[2] = '{set: 64'hFFFE_7FFF_0001_8000, a0: 24'h000103, b0: 8'hFB};

    // Reset values.
    do_reset();
    chk("rst_wr_en", wr_en_a, 0);
    chk("rst_wr_data", wr_data_a, 0);
    chk("rst_wr_addr_a", wr_addr_a, 24'h000100);
    chk("rst_wr_addr_b", wr_addr_b, 8'hF8);
    chk("rst_overflow", ovf_a, 0);
    chk("rst_done", done_a, 0);

    // Single set: latency and band ordering.
    s = 64'h0044_0033_0022_0011;
    wr_ready = 1'b1;
    push(s);
    chk("lat_e0_wr_en", wr_en_a, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("lat_wr_en", wr_en_a, 1);
      chk("lat_data", wr_data_a, s[k*16 +: 16]);
      chk("lat_addr_a", wr_addr_a, addr_a(k, 0));
      chk("lat_addr_b", wr_addr_b, addr_b(k, 0));
    end
    tick();
    chk("lat_e5_wr_en", wr_en_a, 0);
    repeat (2) tick();

    // Table of further single sets at increasing sample index.
    for (int i = 0; i < 3; i++) begin
      cap_a.delete();
      cap_b.delete();
      push(tbl[i].set);
      wait_caps(4, 40);
      s = tbl[i].set;
      for (int b = 0; b < 4; b++) begin
        if (cap_a.size() > b && cap_b.size() > b) begin
          pa = tbl[i].a0 + 24'(b * 'h1000);
          pb = tbl[i].b0 + 8'(b * 4);
          chk("tbl_a", cap_a[b], {pa, s[b*16 +: 16]});
          chk("tbl_b", cap_b[b], {pb, s[b*16 +: 16]});
        end
      end
    end

    // Backpressure: ready one cycle in three, three sets on consecutive cycles.
    do_reset();
    for (int j = 0; j < 3; j++) bp_sets[j] = {$urandom, $urandom};
    c = 0;
    while (cap_a.size() < 12 && c < 100) begin
      in_valid = (c < 3);
      if (c < 3) {d_hh, d_hl, d_lh, d_ll} = bp_sets[c];
      wr_ready = ((c % 3) == 2);
      stalled = wr_en_a && !wr_ready;
      pd = wr_data_a;
      pa = wr_addr_a;
      tick();
      c++;
      if (stalled) begin
        chk("stall_data", wr_data_a, pd);
        chk("stall_addr", wr_addr_a, pa);
      end
    end
    in_valid = 1'b0;
    wr_ready = 1'b0;
    wait_caps(12, 20);
    for (int i = 0; i < 12; i++) begin
      if (cap_a.size() > i) begin
        s = bp_sets[i/4];
        chk("bp_order", cap_a[i], {addr_a(i % 4, i / 4), s[(i%4)*16 +: 16]});
      end
    end

    // Overflow: nine sets into a stalled eight-deep FIFO.
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      push({4{16'(i)}});
      if (i == 8) chk("ovf_before_9th", ovf_a, 0);
    end
    chk("ovf_after_9th_a", ovf_a, 1);
    chk("ovf_after_9th_b", ovf_b, 1);
    wr_ready = 1'b1;
    wait_caps(32, 200);
    for (int i = 0; i < 32; i++) begin
      if (cap_a.size() > i) chk("ovf_set_id", cap_a[i][15:0], 16'(i / 4 + 1));
    end

    // Full FIFO: push on the same edge as the head's last word.
    do_reset();
    for (int i = 1; i <= 8; i++) push({4{16'(i)}});
    chk("full_no_ovf", ovf_a, 0);
    wr_ready = 1'b1;
    tick();
    tick();
    tick();
    push({4{16'd9}});
    wr_ready = 1'b0;
    chk("pop_push_words", cap_a.size(), 4);
    chk("pop_push_no_ovf", ovf_a, 0);
    push({4{16'd10}});
    chk("still_full_ovf", ovf_a, 1);
    wr_ready = 1'b1;
    wait_caps(36, 200);
    for (int i = 0; i < 36; i++) begin
      if (cap_a.size() > i) chk("pop_push_set_id", cap_a[i][15:0], 16'(i / 4 + 1));
    end

    // Index wrap on the narrow instance, and done timing.
    do_reset();
    wr_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      push({16'hD000 + 16'(i), 16'hC000 + 16'(i), 16'hB000 + 16'(i), 16'hA000 + 16'(i)});
    end
    finish_in = 1'b1;
    tick();
    finish_in = 1'b0;
    c = 0;
    while (cap_a.size() < 20 && c < 100) begin
      chk("done_early", done_a, 0);
      tick();
      c++;
    end
    chk("done_at_last_a", done_a, 1);
    chk("done_at_last_b", done_b, 1);
    s = 64'hD005_C005_B005_A005;
    for (int b = 0; b < 4; b++) begin
      if (cap_b.size() > 16 + b) chk("wrap_b", cap_b[16+b], {addr_b(b, 0), s[b*16 +: 16]});
    end
    if (cap_a.size() > 16) chk("nowrap_a", cap_a[16][39:16], 24'h000104);
    push(64'h4444_3333_2222_1111);
    wait_caps(24, 40);
    chk("done_sticky", done_a, 1);
    if (cap_b.size() > 20) chk("after_done_b", cap_b[20], {8'hF9, 16'h1111});

    // Reset in the middle of band 2 with sets still buffered.
    do_reset();
    for (int i = 1; i <= 3; i++) push({4{16'(i)}});
    wr_ready = 1'b1;
    tick();
    tick();
    wr_ready = 1'b0;
    chk("mid_band2_addr", wr_addr_a, addr_a(2, 0));
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midrst_wr_en", wr_en_a, 0);
    chk("midrst_wr_data", wr_data_a, 0);
    chk("midrst_addr_a", wr_addr_a, 24'h000100);
    chk("midrst_addr_b", wr_addr_b, 8'hF8);
    chk("midrst_ovf", ovf_a, 0);
    chk("midrst_done", done_a, 0);
    cap_a.delete();
    cap_b.delete();
    s = 64'h0BAD_F00D_CAFE_BEEF;
    wr_ready = 1'b1;
    push(s);
    wait_caps(4, 40);
    for (int b = 0; b < 4; b++) begin
      if (cap_a.size() > b) chk("midrst_new_set", cap_a[b], {addr_a(b, 0), s[b*16 +: 16]});
    end

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 99) < ((i < 1500) ? 18 : 35));
      {d_hh, d_hl, d_lh, d_ll} = {$urandom, $urandom};
      wr_ready = ($urandom_range(0, 99) < 70);
      finish_in = (i == 2800);
      tick();
    end
    in_valid = 1'b0;
    finish_in = 1'b0;
    wr_ready = 1'b1;
    repeat (60) tick();
    chk("rand_drained", wr_en_a, 0);
    chk("rand_done", done_a, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
